rom_mapping_mc: RTL and testbench

ROM_MAPPING_MC -- requirements
Module: rom_mapping_mc

---
 rtl/rom_mapping_mc.sv | 178 +++++++++++++++++
 tb/tb_rom_mapping_mc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_mapping_mc.sv
// rom_mapping_mc
// Multi-channel phase-to-ROM mapper with serial output. On each accepted
// frame tick, every channel in turn computes a ROM address from a shared
// phase accumulator plus its own offset, waits for the synchronous ROM,
// then shifts the returned word out MSB first. The accumulator advances
// by `step` only after the last channel of the frame has been shifted.
//
// Ports
//   clk, rst      : system clock, synchronous active-high reset
//   en, tick      : frame request (tick honoured only when en=1 and idle)
//   step          : phase increment applied at frame end
//   phase_offset  : NCH packed per-channel phase offsets
//   rom_addr      : registered address to the external synchronous ROM
//   rom_data      : ROM word, valid one clock after rom_addr changes
//   soc           : start-of-frame pulse (first FETCH cycle)
//   SO, SI_en     : serial data (MSB first) and its qualifier
//   load          : one-cycle pulse after each channel word
//   ch_idx        : channel being fetched or shifted
//   busy          : frame in progress
//   overrun       : one-cycle pulse for a tick dropped while busy
module rom_mapping_mc #(
  parameter int DATA_WIDTH  = 12,
  parameter int PHASE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int NCH         = 2,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       tick,
  input  logic [PHASE_WIDTH-1:0]     step,
  input  logic [NCH*PHASE_WIDTH-1:0] phase_offset,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_data,
  output logic                       soc,
  output logic                       SO,
  output logic                       SI_en,
  output logic                       load,
  output logic [CW-1:0]              ch_idx,
  output logic                       busy,
  output logic                       overrun
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    LOAD  = 3'd4
  } state_t;

  state_t                 state_r, state_n;
  logic [PHASE_WIDTH-1:0] acc_r, acc_n;
  logic [DATA_WIDTH-1:0]  sr_r, sr_n;
  logic [BW-1:0]          cnt_r, cnt_n;
  logic [CW-1:0]          ch_n;
  logic [ADDR_WIDTH-1:0]  addr_n;
  logic                   fetch_s;
  logic [PHASE_WIDTH-1:0] off_s;
  logic [PHASE_WIDTH-1:0] sum_s;

  // Offset of the channel about to be fetched (the next-cycle channel index).
  always_comb begin
    off_s = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_n == CW'(k)) begin
        off_s = phase_offset[k*PHASE_WIDTH +: PHASE_WIDTH];
      end else begin
        off_s = off_s;
      end
    end
  end

  // Wrapping phase sum; the ROM address is its top ADDR_WIDTH bits.
  always_comb begin
    sum_s = acc_r + off_s;
  end

  // Next-state, datapath and channel sequencing.
  always_comb begin
    state_n = state_r;
    acc_n   = acc_r;
    sr_n    = sr_r;
    cnt_n   = cnt_r;
    ch_n    = ch_idx;
    fetch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick && en) begin
          state_n = FETCH;
          ch_n    = '0;
          fetch_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      FETCH: begin
        state_n = WAIT;
      end
      WAIT: begin
        // ROM word for this channel is valid now.
        state_n = SHIFT;
        sr_n    = rom_data;
        cnt_n   = '0;
      end
      SHIFT: begin
        sr_n = sr_r << 1;
        if (cnt_r == LAST_BIT) begin
          state_n = LOAD;
        end else begin
          cnt_n = cnt_r + BW'(1);
        end
      end
      LOAD: begin
        if (ch_idx < LAST_CH) begin
          state_n = FETCH;
          ch_n    = ch_idx + CW'(1);
          fetch_s = 1'b1;
        end else begin
          // Frame end: the only place the accumulator moves.
          state_n = IDLE;
          ch_n    = '0;
          acc_n   = acc_r + step;
        end
      end
      default: begin
        state_n = IDLE;
        ch_n    = '0;
      end
    endcase
  end

  // Address is captured on FETCH entry and held until the next fetch.
  always_comb begin
    if (fetch_s) begin
      addr_n = sum_s[PHASE_WIDTH-1 -: ADDR_WIDTH];
    end else begin
      addr_n = rom_addr;
    end
  end

  // State, datapath and registered outputs (outputs decoded from next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= '0;
      sr_r     <= '0;
      cnt_r    <= '0;
      ch_idx   <= '0;
      rom_addr <= '0;
      soc      <= 1'b0;
      SO       <= 1'b0;
      SI_en    <= 1'b0;
      load     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_r  <= state_n;
      acc_r    <= acc_n;
      sr_r     <= sr_n;
      cnt_r    <= cnt_n;
      ch_idx   <= ch_n;
      rom_addr <= addr_n;
      soc      <= fetch_s && (state_r == IDLE);
      SO       <= (state_n == SHIFT) ? sr_n[DATA_WIDTH-1] : 1'b0;
      SI_en    <= (state_n == SHIFT);
      load     <= (state_n == LOAD);
      busy     <= (state_n != IDLE);
      overrun  <= tick && en && (state_r != IDLE);
    end
  end

endmodule

// File: tb/tb_rom_mapping_mc.sv
module tb_rom_mapping_mc;
  localparam int DW = 12;
  localparam int PW = 16;
  localparam int AW = 8;
  localparam int NCH = 2;
  localparam int CL = DW + 3;
  localparam int FL = NCH * CL;

  logic              clk = 1'b0;
  logic              rst, en, tick;
  logic [PW-1:0]     step;
  logic [NCH*PW-1:0] phase_offset;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic              soc, SO, SI_en, load, busy, overrun;
  logic              ch_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rom_mapping_mc #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .step(step),
    .phase_offset(phase_offset), .rom_addr(rom_addr), .rom_data(rom_data),
    .soc(soc), .SO(SO), .SI_en(SI_en), .load(load), .ch_idx(ch_idx),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data = {4'h0, addr}, one clock latency.
  always @(posedge clk) rom_data <= {4'h0, rom_addr};
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Logs of observed DUT behaviour for the directed literal checks.
  logic [DW-1:0] words[$];
  int            load_cyc[$];
  logic [AW-1:0] addrs[$];
  int            soc_cnt = 0, ov_cnt = 0, soc_cyc = 0;
  logic [DW-1:0] collect = '0;

  function automatic logic [31:0] qw(int i);
    return (i < words.size()) ? 32'(words[i]) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] ql(int i);
    return (i < load_cyc.size()) ? 32'(load_cyc[i]) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] qa(int i);
    return (i < addrs.size()) ? 32'(addrs[i]) : 32'hDEAD;
  endfunction

  // Behavioural model: position within frame (0 = idle, 1..FL) plus acc.
  int            mp = 0;
  logic [PW-1:0] macc = '0;
  logic [AW-1:0] maddr = '0;
  logic          mov = 1'b0;

  always @(negedge clk) begin
    int mq, mch;
    logic [DW-1:0] w;
    logic          esi, eso;
    logic [PW-1:0] sum;
    mq  = (mp == 0) ? 0 : (mp - 1) % CL;
    mch = (mp == 0) ? 0 : (mp - 1) / CL;
    w   = {4'h0, maddr};
    esi = (mp != 0) && (mq >= 2) && (mq <= DW + 1);
    eso = esi ? w[DW - 1 - (mq - 2)] : 1'b0;
    chk("busy", 32'(busy), 32'(mp != 0));
    chk("soc", 32'(soc), 32'(mp == 1));
    chk("si_en", 32'(SI_en), 32'(esi));
    chk("so", 32'(SO), 32'(eso));
    chk("load", 32'(load), 32'((mp != 0) && (mq == CL - 1)));
    chk("ch_idx", 32'(ch_idx), 32'(mch));
    chk("rom_addr", 32'(rom_addr), 32'(maddr));
    chk("overrun", 32'(overrun), 32'(mov));
    // observation logs
    if (SI_en) collect = {collect[DW-2:0], SO};
    if (load) begin words.push_back(collect); load_cyc.push_back(cyc); end
    if (soc) begin soc_cnt++; soc_cyc = cyc; end
    if (overrun) ov_cnt++;
    if (mp != 0 && mq == 0) addrs.push_back(rom_addr);
    // advance model using inputs that the next rising edge will sample
    if (rst) begin
      mp = 0; macc = '0; maddr = '0; mov = 1'b0;
    end else begin
      mov = tick && en && (mp != 0);
      if (mp == 0) begin
        if (tick && en) mp = 1;
      end else if (mp == FL) begin
        mp = 0;
        macc = macc + step;
      end else begin
        mp++;
      end
      if (mp != 0 && (mp - 1) % CL == 0) begin
        sum = macc + phase_offset[((mp - 1) / CL) * PW +: PW];
        maddr = sum[PW-1 -: AW];
      end
    end
  end

  task automatic cyc1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log;
    words.delete(); load_cyc.delete(); addrs.delete();
    soc_cnt = 0; ov_cnt = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1; tick = 1'b0;
    repeat (3) cyc1();
    rst = 1'b0;
    cyc1();
  endtask

  task automatic fire(output int t);
    tick = 1'b1; en = 1'b1; t = cyc;
    cyc1();
    tick = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1; en = 1'b0; tick = 1'b0;
    step = 16'h0100; phase_offset = {16'h4000, 16'h0000};
    repeat (3) cyc1();
    rst = 1'b0;
    repeat (2) cyc1();
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_addr", 32'(rom_addr), 32'h0);

    // basic frame
    clr_log(); fire(t); repeat (32) cyc1();
    chk("t1_soc_cyc", 32'(soc_cyc), 32'(t + 1));
    chk("t1_nloads", 32'(load_cyc.size()), 32'd2);
    chk("t1_load0", ql(0), 32'(t + 15));
    chk("t1_load1", ql(1), 32'(t + 30));
    chk("t1_addr0", qa(0), 32'h00);
    chk("t1_addr1", qa(1), 32'h40);
    chk("t1_word0", qw(0), 32'h000);
    chk("t1_word1", qw(1), 32'h040);

    // second frame sees acc advanced by step
    clr_log(); fire(t); repeat (32) cyc1();
    chk("t2_word0", qw(0), 32'h001);
    chk("t2_word1", qw(1), 32'h041);

    // wrap of phase + offset
    do_reset(); step = 16'h8000; phase_offset = {16'hC000, 16'h0000};
    clr_log(); fire(t); repeat (32) cyc1(); fire(t); repeat (32) cyc1();
    chk("t3_f1_ch1", qa(1), 32'hC0);
    chk("t3_f2_ch0", qa(2), 32'h80);
    chk("t3_f2_ch1", qa(3), 32'h40);

    // overrun mid-frame
    do_reset(); step = 16'h0100; phase_offset = {16'h4000, 16'h0000};
    clr_log(); fire(t); repeat (9) cyc1();
    tick = 1'b1; cyc1(); tick = 1'b0;
    repeat (40) cyc1();
    chk("t4_ov_cnt", 32'(ov_cnt), 32'd1);
    chk("t4_soc_cnt", 32'(soc_cnt), 32'd1);
    chk("t4_word0", qw(0), 32'h000);
    chk("t4_word1", qw(1), 32'h040);
    chk("t4_load0", ql(0), 32'(t + 15));
    chk("t4_load1", ql(1), 32'(t + 30));

    // tick during last LOAD cycle is an overrun, not a new frame
    clr_log(); fire(t); repeat (29) cyc1();
    tick = 1'b1; cyc1(); tick = 1'b0;
    repeat (5) cyc1();
    chk("t5_ov_cnt", 32'(ov_cnt), 32'd1);
    chk("t5_soc_cnt", 32'(soc_cnt), 32'd1);
    chk("t5_busy", 32'(busy), 32'h0);

    // tick with en=0 ignored, acc unchanged (two frames done -> 0x0200)
    clr_log(); en = 1'b0; tick = 1'b1; cyc1(); tick = 1'b0;
    repeat (5) cyc1();
    chk("t6_soc_cnt", 32'(soc_cnt), 32'd0);
    fire(t); repeat (32) cyc1();
    chk("t6_word0", qw(0), 32'h002);
    chk("t6_word1", qw(1), 32'h042);

    // reset mid-frame aborts with no load; next frame restarts from acc=0
    clr_log(); fire(t); repeat (7) cyc1();
    rst = 1'b1; cyc1(); rst = 1'b0;
    repeat (3) cyc1();
    chk("t7_no_load", 32'(load_cyc.size()), 32'd0);
    fire(t); repeat (32) cyc1();
    chk("t7_word0", qw(0), 32'h000);
    chk("t7_word1", qw(1), 32'h040);

    // randomized traffic against the model
    clr_log();
    repeat (3000) begin
      tick = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 7) != 0);
      rst  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) step = PW'($urandom);
      if ($urandom_range(0, 99) == 0) phase_offset = $urandom;
      cyc1();
    end
    rst = 1'b0; tick = 1'b0;
    repeat (40) cyc1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
